// File: rtl/mux_scan_ctrl_if.sv
// Frame handshake between the scan controller and its downstream consumer.
interface mux_scan_ctrl_if;
    logic [3:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin select/sample controller for mux_4_1; frame is ready N*DWELL edges after start.
// frame_valid/frame_data hold until frame_ready; backpressure stalls the scan indefinitely.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      enable_mask,
    input  logic            continuous,
    input  logic            y_in,
    output logic            sel0,
    output logic            sel1,
    output logic            busy,
    mux_scan_ctrl_if.master frame
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    logic [1:0]       ch;
    logic [3:0]       data_q;
    logic             valid_q;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur; only meaningful when has_higher is true.
    function automatic logic [1:0] next_higher(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        r = cur;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic has_higher(input logic [3:0] m, input logic [1:0] cur);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (i > int'(cur))) f = 1'b1;
        end
        return f;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            mask_q  <= 4'd0;
            ch      <= 2'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            ch      <= 2'd0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (enable_mask != 4'd0)) begin
                        mask_q <= enable_mask;
                        data_q <= 4'd0;
                        ch     <= lowest(enable_mask);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SELECT;
                    end
                end
                SELECT: begin
                    if (cnt == LAST) begin
                        data_q[ch] <= y_in;
                        cnt        <= '0;
                        if (has_higher(mask_q, ch)) begin
                            ch <= next_higher(mask_q, ch);
                        end else begin
                            valid_q <= 1'b1;
                            state   <= OUTPUT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (frame.frame_ready) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        // Continuous mode restarts straight from the handshake edge.
                        if (continuous && (enable_mask != 4'd0)) begin
                            mask_q <= enable_mask;
                            data_q <= 4'd0;
                            ch     <= lowest(enable_mask);
                            state  <= SELECT;
                        end else begin
                            ch    <= 2'd0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ch      <= 2'd0;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sel0              = ch[0];
    assign sel1              = ch[1];
    assign frame.frame_data  = data_q;
    assign frame.frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: two controllers (DWELL=4 and DWELL=1), each feeding a behavioural mux_4_1.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       go0, go1, abort, continuous;
    logic [3:0] enable_mask;
    logic [3:0] iv0, iv1;
    logic       sel0_0, sel1_0, busy0, y0;
    logic       sel0_1, sel1_1, busy1, y1;

    int checks = 0;
    int errors = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    mux_scan_ctrl_if f0 ();
    mux_scan_ctrl_if f1 ();

    assign y0 = iv0[{sel1_0, sel0_0}];
    assign y1 = iv1[{sel1_1, sel0_1}];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(go0), .abort(abort), .enable_mask(enable_mask),
        .continuous(continuous), .y_in(y0), .sel0(sel0_0), .sel1(sel1_0), .busy(busy0),
        .frame(f0.master)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(go1), .abort(abort), .enable_mask(enable_mask),
        .continuous(continuous), .y_in(y1), .sel0(sel0_1), .sel1(sel1_1), .busy(busy1),
        .frame(f1.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start0(input logic [3:0] m);
        enable_mask = m;
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
    endtask

    // Scoreboard monitors: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && f0.frame_valid && f0.frame_ready) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_frame", {28'd0, f0.frame_data}, 32'hffff);
            end else begin
                chk("u0_frame_data", {28'd0, f0.frame_data}, {28'd0, q0.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && f1.frame_valid && f1.frame_ready) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_frame", {28'd0, f1.frame_data}, 32'hffff);
            end else begin
                chk("u1_frame_data", {28'd0, f1.frame_data}, {28'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        int seen_valid;
        rst = 1'b1;
        go0 = 1'b0; go1 = 1'b0; abort = 1'b0; continuous = 1'b0;
        enable_mask = 4'd0; iv0 = 4'd0; iv1 = 4'd0;
        f0.frame_ready = 1'b1;
        f1.frame_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_sel", {30'd0, sel1_0, sel0_0}, 32'd0);
        chk("rst_data", {28'd0, f0.frame_data}, 32'd0);
        chk("rst_valid", {31'd0, f0.frame_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        tick();

        // Full scan, i0..i3 = 1,0,1,1
        iv0 = 4'b1101;
        q0.push_back(4'b1101);
        start0(4'b1111);
        chk("t1_sel_e0", {30'd0, sel1_0, sel0_0}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k < 16) chk("t1_sel", {30'd0, sel1_0, sel0_0}, 32'(k / 4));
            if (k == 15) chk("t1_valid_early", {31'd0, f0.frame_valid}, 32'd0);
            if (k == 16) chk("t1_valid", {31'd0, f0.frame_valid}, 32'd1);
            if (k == 17) begin
                chk("t1_busy_idle", {31'd0, busy0}, 32'd0);
                chk("t1_valid_idle", {31'd0, f0.frame_valid}, 32'd0);
                chk("t1_sel_idle", {30'd0, sel1_0, sel0_0}, 32'd0);
            end
        end

        // Sparse mask 1010
        iv0 = 4'b0010;
        q0.push_back(4'b0010);
        start0(4'b1010);
        chk("t2_sel_e0", {30'd0, sel1_0, sel0_0}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) chk("t2_sel_ch1", {30'd0, sel1_0, sel0_0}, 32'd1);
            if (k == 4) chk("t2_sel_ch3", {30'd0, sel1_0, sel0_0}, 32'd3);
            if (k == 7) chk("t2_valid_early", {31'd0, f0.frame_valid}, 32'd0);
            if (k == 8) chk("t2_valid", {31'd0, f0.frame_valid}, 32'd1);
            if (k == 9) chk("t2_busy_idle", {31'd0, busy0}, 32'd0);
        end

        // Backpressure on a single-channel frame
        iv0 = 4'b0001;
        f0.frame_ready = 1'b0;
        q0.push_back(4'b0001);
        start0(4'b0001);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 3) chk("t3_valid_early", {31'd0, f0.frame_valid}, 32'd0);
            if (k == 5) iv0 = 4'b0000;
            if (k >= 4) begin
                chk("t3_stall_valid", {31'd0, f0.frame_valid}, 32'd1);
                chk("t3_stall_data", {28'd0, f0.frame_data}, 32'd1);
            end
        end
        f0.frame_ready = 1'b1;
        tick();
        chk("t3_busy_idle", {31'd0, busy0}, 32'd0);
        chk("t3_valid_drop", {31'd0, f0.frame_valid}, 32'd0);

        // Continuous mode, i2 toggled between frames
        continuous = 1'b1;
        iv0 = 4'b0100;
        q0.push_back(4'b0100);
        q0.push_back(4'b0000);
        q0.push_back(4'b0100);
        start0(4'b1100);
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 9)  iv0 = 4'b0000;
            if (k == 18) iv0 = 4'b0100;
            if (k == 20) continuous = 1'b0;
            if (k <= 26) chk("t4_busy", {31'd0, busy0}, 32'd1);
            if (k <= 26) chk("t4_valid", {31'd0, f0.frame_valid},
                             {31'd0, (k == 8) || (k == 17) || (k == 26)});
            if (k == 9 || k == 18) chk("t4_sel_restart", {30'd0, sel1_0, sel0_0}, 32'd2);
            if (k == 27) chk("t4_busy_idle", {31'd0, busy0}, 32'd0);
        end

        // Abort at edge 7 of a full scan
        iv0 = 4'b1111;
        start0(4'b1111);
        for (int k = 1; k <= 6; k++) tick();
        chk("t5_busy_pre_abort", {31'd0, busy0}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", {31'd0, busy0}, 32'd0);
        chk("t5_abort_sel", {30'd0, sel1_0, sel0_0}, 32'd0);
        seen_valid = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (f0.frame_valid) seen_valid++;
        end
        chk("t5_abort_no_valid", 32'(seen_valid), 32'd0);

        // Mask change mid-scan has no effect
        iv0 = 4'b0001;
        q0.push_back(4'b0001);
        start0(4'b0011);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) enable_mask = 4'b1100;
            if (k == 4) chk("t6_sel_ch1", {30'd0, sel1_0, sel0_0}, 32'd1);
            if (k == 8) chk("t6_valid", {31'd0, f0.frame_valid}, 32'd1);
            if (k == 9) chk("t6_busy_idle", {31'd0, busy0}, 32'd0);
        end

        // Asynchronous reset mid-scan
        iv0 = 4'b1111;
        start0(4'b1111);
        for (int k = 1; k <= 5; k++) tick();
        chk("t7_data_before_rst", {28'd0, f0.frame_data}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_sel", {30'd0, sel1_0, sel0_0}, 32'd0);
        chk("t7_rst_data", {28'd0, f0.frame_data}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy0}, 32'd0);
        chk("t7_rst_valid", {31'd0, f0.frame_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Start with an empty mask is ignored
        start0(4'b0000);
        chk("t8_busy_mask0", {31'd0, busy0}, 32'd0);
        tick();
        chk("t8_busy_mask0_later", {31'd0, busy0}, 32'd0);

        // DWELL=1 instance: one sample per edge
        iv1 = 4'b1010;
        q1.push_back(4'b1010);
        enable_mask = 4'b1111;
        go1 = 1'b1;
        tick();
        go1 = 1'b0;
        chk("t9_sel_e0", {30'd0, sel1_1, sel0_1}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 3) chk("t9_sel", {30'd0, sel1_1, sel0_1}, 32'(k));
            if (k == 3) chk("t9_valid_early", {31'd0, f1.frame_valid}, 32'd0);
            if (k == 4) chk("t9_valid", {31'd0, f1.frame_valid}, 32'd1);
            if (k == 5) chk("t9_busy_idle", {31'd0, busy1}, 32'd0);
        end

        tick();
        chk("sb_u0_drained", 32'(q0.size()), 32'd0);
        chk("sb_u1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
